req_arbiter: RTL and testbench
==============================

Name: req_arbiter

Overview:
Arbitrates ownership of one shared resource among 8 requesters. Selectable fixed-priority or round-robin policy, with a registered one-hot and encoded grant. The grant is held until the owner releases it, drops its request, or hits a hold timeout. It sits in front of the shared datapath and drives that datapath's select/enable from gnt_id/gnt_valid. Fixed-priority order matches the team's 8:3 priority encoding: index 7 is highest.

Parameters:
N_REQ, 8, number of requesters (fixed at 8; ID width 3)
MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 disables the timeout
CNT_W, 5, hold counter width; must hold MAX_HOLD

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous reset, active-high
rr_mode  in  1  1 = round-robin, 0 = fixed priority; sampled only in IDLE
req  in  8  request vector, level-sensitive, bit i = requester i
done  in  1  release strobe from the current owner; ignored when gnt_valid=0
gnt  out  8  one-hot grant, registered
gnt_id  out  3  encoded index of the granted requester, registered
gnt_valid  out  1  1 while a grant is active, registered
timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0
  - hold_cnt=0, last_id=0, mask_id_valid=0
  - Reset mid-grant drops the grant on the next edge; no release cycle is emitted.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req (after masking) is nonzero, select the winner. On the next edge: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1, last_id=winner, state=GRANT.
  - Latency is 1 cycle from req sampled in IDLE to gnt visible.
  - If req is all zero, stay in IDLE and keep outputs at 0.
- Winner selection:
  - Fixed (rr_mode=0): highest set index wins.
  - Round-robin (rr_mode=1): search descending starting at (last_id-1) mod 8, wrapping 0->7. The first set bit wins, so last_id has the lowest priority.
  - After reset, last_id=0, so the RR search starts at 7 and both modes agree.
- Masking:
  - If mask_id_valid=1, bit mask_id is excluded from req for that single IDLE decision, but only when another bit is set.
  - If mask_id is the only requester, it is granted.
  - mask_id_valid clears after any IDLE decision that grants.
- GRANT:
  - Outputs hold and hold_cnt increments each cycle, saturating at MAX_HOLD.
  - Exit conditions, evaluated each cycle:
    - (a) done=1
    - (b) req[gnt_id]=0
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD
  - On any exit, next edge: gnt=0, gnt_valid=0, state=RELEASE. gnt_id holds its last value.
  - If (c) is the exit cause and neither (a) nor (b) is true that cycle: timeout=1 for exactly that next cycle, mask_id=gnt_id, mask_id_valid=1.
  - If (a) or (b) coincides with (c): normal release, no timeout, no mask.
  - With MAX_HOLD=1, every grant lasts exactly 1 cycle.
- RELEASE:
  - One dead cycle with gnt_valid=0, guaranteeing a bus turnaround; then state=IDLE unconditionally.
  - Minimum gap between the end of one grant and the start of the next is 2 cycles (RELEASE, then IDLE decision).
- rr_mode, req changes of non-owners, and done while idle have no effect outside IDLE decisions.
- gnt is always one-hot or zero. gnt_valid == |gnt. gnt_id == encode(gnt) whenever gnt_valid=1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_id=0, gnt_valid=0, timeout=0 throughout. Release rst -> gnt=8'h80, gnt_id=7 exactly one cycle after the first IDLE cycle.
- Fixed priority: rr_mode=0, req=8'b0010_0110, owner asserts done after 3 grant cycles -> grants in order id 5, then 2 (after done), then 1. Each grant has gnt_valid=0 for 1 RELEASE cycle between grants.
- Round-robin fairness: rr_mode=1, req=8'hFF constant, done pulsed on every grant's 2nd cycle -> gnt_id sequence 7,6,5,4,3,2,1,0,7; each id is granted once per 8 grants.
- Timeout: MAX_HOLD=4, rr_mode=0, req=8'h81, done=0 -> id 7 holds for 4 cycles, then timeout=1 for 1 cycle, then id 0 is granted. Next grant is id 7 again, so the mask applies to one decision only.
- Sole requester after timeout: MAX_HOLD=4, req=8'h04 only -> timeout pulse, RELEASE, then id 2 is re-granted (mask not applied).
- Owner drop and reset mid-grant: req[3] falls during its grant -> gnt=0 on the next edge with no timeout. Assert rst during a later grant -> all outputs 0 on the next edge, and last_id resets so the next RR grant is id 7 when req=8'hFF.

Source files
------------

// File: rtl/req_arbiter.sv
// req_arbiter: grants one shared resource to one of N_REQ requesters.
//
// Policy is fixed priority (highest index wins) or round-robin (search
// descending from last_id-1, so the previous owner has the lowest priority),
// chosen by rr_mode at each IDLE decision. A grant is held until the owner
// pulses done, drops its request, or has held for MAX_HOLD cycles. Every grant
// is followed by one RELEASE cycle with nothing granted (bus turnaround).
// A timed-out owner is masked out of the next decision unless it is the only
// requester.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   rr_mode    1 = round-robin, 0 = fixed priority (used only in IDLE)
//   req        level-sensitive request vector, bit i = requester i
//   done       release strobe from the current owner
//   gnt        registered one-hot grant
//   gnt_id     registered encoded grant index (holds after release)
//   gnt_valid  registered, 1 while a grant is active
//   timeout    one-cycle pulse when a grant is revoked by MAX_HOLD
module req_arbiter #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 16,  // 0 disables the hold timeout
  parameter int unsigned CNT_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rr_mode,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid,
  output logic                     timeout
);

  localparam int unsigned IdW = $clog2(N_REQ);

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);
  // With the timeout disabled the counter still saturates, just at all-ones.
  localparam logic [CNT_W-1:0] HoldSat = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HoldMax;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IdW-1:0]     gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IdW-1:0]     last_id_q, last_id_d;
  logic [IdW-1:0]     mask_id_q, mask_id_d;
  logic               mask_id_valid_q, mask_id_valid_d;

  // Winner selection
  logic [N_REQ-1:0]   mask_vec;
  logic [N_REQ-1:0]   req_rest;
  logic [N_REQ-1:0]   req_eff;
  logic [N_REQ-1:0]   req_rot;
  logic [IdW-1:0]     base_id;
  logic [IdW-1:0]     win_off;
  logic [IdW-1:0]     win_id;

  always_comb begin
    mask_vec = mask_id_valid_q ? (N_REQ'(1) << mask_id_q) : '0;
    req_rest = req & ~mask_vec;
    // The masked requester is only excluded if somebody else is asking.
    req_eff  = (|req_rest) ? req_rest : req;

    // Rotate so that bit j of req_rot is requester (base_id + j) mod N_REQ.
    // Bit N_REQ-1 is then requester base_id-1, the first one the round-robin
    // search visits, and a plain highest-bit pick implements both policies.
    base_id  = rr_mode ? last_id_q : '0;
    req_rot  = N_REQ'({req_eff, req_eff} >> base_id);

    win_off = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_rot[i]) begin
        win_off = IdW'(i);
      end
    end
    // Wraps modulo N_REQ (power of two).
    win_id = base_id + win_off;
  end

  // Next-state / outputs
  logic hold_hit;
  logic owner_exit;

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_id_d        = gnt_id_q;
    gnt_valid_d     = gnt_valid_q;
    timeout_d       = 1'b0;
    hold_cnt_d      = hold_cnt_q;
    last_id_d       = last_id_q;
    mask_id_d       = mask_id_q;
    mask_id_valid_d = mask_id_valid_q;

    hold_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HoldMax);
    owner_exit = done || !req[gnt_id_q];

    unique case (state_q)
      StIdle: begin
        if (|req_eff) begin
          state_d         = StGrant;
          gnt_d           = N_REQ'(1) << win_id;
          gnt_id_d        = win_id;
          gnt_valid_d     = 1'b1;
          hold_cnt_d      = CNT_W'(1);
          last_id_d       = win_id;
          mask_id_valid_d = 1'b0;
        end
      end

      StGrant: begin
        if (owner_exit || hold_hit) begin
          state_d     = StRelease;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // A voluntary release in the same cycle wins over the timeout.
          if (!owner_exit) begin
            timeout_d       = 1'b1;
            mask_id_d       = gnt_id_q;
            mask_id_valid_d = 1'b1;
          end
        end else if (hold_cnt_q != HoldSat) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      StRelease: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      gnt_q           <= '0;
      gnt_id_q        <= '0;
      gnt_valid_q     <= 1'b0;
      timeout_q       <= 1'b0;
      hold_cnt_q      <= '0;
      last_id_q       <= '0;
      mask_id_q       <= '0;
      mask_id_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      gnt_id_q        <= gnt_id_d;
      gnt_valid_q     <= gnt_valid_d;
      timeout_q       <= timeout_d;
      hold_cnt_q      <= hold_cnt_d;
      last_id_q       <= last_id_d;
      mask_id_q       <= mask_id_d;
      mask_id_valid_q <= mask_id_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_valid_or: assert property (@(posedge clk) disable iff (rst) gnt_valid_q == (|gnt_q));
  a_id_encode: assert property (@(posedge clk) disable iff (rst)
    gnt_valid_q |-> (gnt_q == (N_REQ'(1) << gnt_id_q)));
`endif

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: directed scenarios plus a randomized run checked
// against a behavioural model of the arbitration rules.
module tb_req_arbiter;

  localparam int unsigned MaxHold = 4;

  logic       clk;
  logic       rst;
  logic       rr_mode;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  req_arbiter #(
    .N_REQ   (8),
    .MAX_HOLD(MaxHold),
    .CNT_W   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rr_mode  (rr_mode),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: 0 = idle, 1 = owned, 2 = turnaround
  int         m_phase  = 0;
  int         m_owner  = 0;
  int         m_held   = 0;
  int         m_last   = 0;
  int         m_mask   = 0;
  bit         m_mask_v = 1'b0;
  logic [7:0] e_gnt    = 8'h00;
  logic [2:0] e_id     = 3'd0;
  logic       e_valid  = 1'b0;
  logic       e_to     = 1'b0;

  // First requester found walking downward from 'start', wrapping 7 after 0.
  function automatic int pick(input logic [7:0] v, input logic rr, input int last);
    int start;
    start = rr ? (last + 7) % 8 : 7;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (start - k + 8) % 8;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [7:0] others;
    logic [7:0] cand;
    int         w;
    bit         vol;
    bit         lim;
    if (rst) begin
      m_phase = 0; m_held = 0; m_last = 0; m_mask = 0; m_mask_v = 1'b0;
      e_gnt = 8'h00; e_id = 3'd0; e_valid = 1'b0; e_to = 1'b0;
    end else begin
      e_to = 1'b0;
      case (m_phase)
        0: begin
          cand   = req;
          others = req & ~(8'h01 << m_mask);
          if (m_mask_v && others != 8'h00) cand = others;
          if (cand != 8'h00) begin
            w        = pick(cand, rr_mode, m_last);
            m_owner  = w;
            m_last   = w;
            m_held   = 1;
            m_mask_v = 1'b0;
            m_phase  = 1;
            e_gnt    = 8'h01 << w;
            e_id     = 3'(w);
            e_valid  = 1'b1;
          end
        end
        1: begin
          vol = done || !req[m_owner];
          lim = (MaxHold != 0) && (m_held == MaxHold);
          if (vol || lim) begin
            m_phase = 2;
            e_gnt   = 8'h00;
            e_valid = 1'b0;
            if (!vol) begin
              e_to     = 1'b1;
              m_mask   = m_owner;
              m_mask_v = 1'b1;
            end
          end else if (MaxHold == 0 || m_held < MaxHold) begin
            m_held++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drain();
    req  = 8'h00;
    done = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; done = 1'b0; rr_mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold%0d: gnt=%h id=%0d valid=%b to=%b, want all 0",
                 k, gnt, gnt_id, gnt_valid, timeout);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'h80 || gnt_id !== 3'd7 || gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant: gnt=%h id=%0d valid=%b, want gnt=80 id=7 valid=1",
               gnt, gnt_id, gnt_valid);
    end
    drain();
  endtask

  task automatic test_fixed_priority();
    logic [2:0] exp_ids [3];
    exp_ids = '{3'd5, 3'd2, 3'd1};
    rr_mode = 1'b0; req = 8'b0010_0110; done = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_id !== exp_ids[g] || gnt !== (8'h01 << exp_ids[g])) begin
        failures++;
        $display("FAIL fixed_grant%0d: gnt=%h id=%0d valid=%b, want id=%0d valid=1",
                 g, gnt, gnt_id, gnt_valid, exp_ids[g]);
      end
      tick(); tick();
      done = 1'b1;
      req[exp_ids[g]] = 1'b0;
      tick();
      checks++;
      if (gnt_valid !== 1'b0 || gnt !== 8'h00 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL fixed_release%0d: gnt=%h valid=%b to=%b, want 00/0/0",
                 g, gnt, gnt_valid, timeout);
      end
      done = 1'b0;
      tick();
      checks++;
      if (gnt_valid !== 1'b0) begin
        failures++;
        $display("FAIL fixed_gap%0d: valid=%b, want 0", g, gnt_valid);
      end
    end
    drain();
  endtask

  task automatic test_round_robin();
    int counts [8];
    for (int i = 0; i < 8; i++) counts[i] = 0;
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0; rr_mode = 1'b1; req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      logic [2:0] want;
      want = 3'(7 - (g % 8));
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_id !== want) begin
        failures++;
        $display("FAIL rr_grant%0d: id=%0d valid=%b, want id=%0d valid=1",
                 g, gnt_id, gnt_valid, want);
      end
      if (g < 8 && gnt_valid === 1'b1) counts[gnt_id]++;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (counts[i] != 1) begin
        failures++;
        $display("FAIL rr_fairness_id%0d: granted %0d times in 8, want 1", i, counts[i]);
      end
    end
    drain();
  endtask

  task automatic test_timeout();
    rr_mode = 1'b0; req = 8'h81; done = 1'b0;
    for (int r = 0; r < 2; r++) begin
      logic [2:0] want;
      want = (r == 0) ? 3'd7 : 3'd0;
      for (int k = 0; k < int'(MaxHold); k++) begin
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_id !== want || timeout !== 1'b0) begin
          failures++;
          $display("FAIL timeout_hold_r%0d_c%0d: id=%0d valid=%b to=%b, want id=%0d 1 0",
                   r, k, gnt_id, gnt_valid, timeout, want);
        end
      end
      tick();
      checks++;
      if (timeout !== 1'b1 || gnt_valid !== 1'b0) begin
        failures++;
        $display("FAIL timeout_pulse_r%0d: to=%b valid=%b, want 1 0", r, timeout, gnt_valid);
      end
      tick();
      checks++;
      if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
        failures++;
        $display("FAIL timeout_gap_r%0d: to=%b valid=%b, want 0 0", r, timeout, gnt_valid);
      end
    end
    // Mask from the id-0 timeout applies to this one decision only.
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 3'd7) begin
      failures++;
      $display("FAIL timeout_mask_once: id=%0d valid=%b, want id=7 valid=1", gnt_id, gnt_valid);
    end
    drain();
  endtask

  task automatic test_sole_requester();
    rr_mode = 1'b0; req = 8'h04; done = 1'b0;
    repeat (MaxHold) tick();
    tick();
    checks++;
    if (timeout !== 1'b1 || gnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL sole_pulse: to=%b valid=%b, want 1 0", timeout, gnt_valid);
    end
    tick();
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 3'd2 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL sole_regrant: id=%0d valid=%b to=%b, want id=2 1 0",
               gnt_id, gnt_valid, timeout);
    end
    drain();
  endtask

  task automatic test_owner_drop_reset();
    rr_mode = 1'b0; req = 8'h08; done = 1'b0;
    tick(); tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 3'd3) begin
      failures++;
      $display("FAIL drop_grant: id=%0d valid=%b, want id=3 valid=1", gnt_id, gnt_valid);
    end
    req = 8'h00;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: gnt=%h valid=%b to=%b, want 00 0 0", gnt, gnt_valid, timeout);
    end
    tick();
    rr_mode = 1'b1; req = 8'hFF;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 3'd2) begin
      failures++;
      $display("FAIL rr_after_3: id=%0d valid=%b, want id=2 valid=1", gnt_id, gnt_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL midgrant_reset: gnt=%h id=%0d valid=%b to=%b, want all 0",
               gnt, gnt_id, gnt_valid, timeout);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 3'd7) begin
      failures++;
      $display("FAIL rr_after_reset: id=%0d valid=%b, want id=7 valid=1", gnt_id, gnt_valid);
    end
    drain();
  endtask

  task automatic test_random();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
      end
      done    = ($urandom_range(0, 7) == 0);
      rr_mode = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (gnt !== e_gnt || gnt_valid !== e_valid || timeout !== e_to ||
          (e_valid && gnt_id !== e_id)) begin
        failures++;
        $display("FAIL random_c%0d: gnt=%h id=%0d valid=%b to=%b, want gnt=%h id=%0d valid=%b to=%b",
                 c, gnt, gnt_id, gnt_valid, timeout, e_gnt, e_id, e_valid, e_to);
      end
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; rr_mode = 1'b0; req = 8'h00; done = 1'b0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_sole_requester();
    test_owner_drop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
